// File: rtl/dmem_pkg.sv
// Shared encodings, FSM states and the byte-lane mask helper for the data-memory responder.
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Lanes touched by an access; illegal sizes touch nothing.
    function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] mask;
        mask = 4'b0000;
        case (size)
            SIZE_BYTE: mask = 4'b0001 << offset;
            SIZE_HALF: mask = 4'b0011 << offset;
            SIZE_WORD: mask = 4'b1111;
            default:   mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane steering: store mask and replicated write data, load lane extraction and extension.
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  offset_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  wmask_o,
    output logic [31:0] wdata_rep_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    assign shifted = rword_i >> {offset_i, 3'b000};
    assign wmask_o = byte_mask(size_i, offset_i);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        wdata_rep_o = '0;
        rdata_o     = '0;
        case (size_i)
            SIZE_BYTE: begin
                wdata_rep_o = {4{wdata_i[7:0]}};
                rdata_o     = unsigned_i ? {24'b0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                wdata_rep_o = {2{wdata_i[15:0]}};
                rdata_o     = unsigned_i ? {16'b0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            end
            SIZE_WORD: begin
                wdata_rep_o = wdata_i;
                rdata_o     = rword_i;
            end
            default: begin
                wdata_rep_o = '0;
                rdata_o     = '0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: request handshake, programmable wait states,
// word-organised storage with byte lanes, and a held response until taken.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 1,
    parameter int DBG_ADDR    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] debug_mem_addr_16
);

    localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int         DBG_IDX   = DBG_ADDR / 4;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, unsigned_q;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  size_q;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic             accept, enter_resp, commit;
    logic             acc_write, acc_unsigned, acc_error;
    logic [31:0]      acc_addr, acc_wdata;
    logic [1:0]       acc_size;
    logic [IDX_W-1:0] acc_idx;
    logic [3:0]       wmask;
    logic [31:0]      wdata_rep, load_data;

    // With zero wait states the access happens on the accept edge, so use the live request.
    assign acc_write    = (state_q == IDLE) ? req_write    : write_q;
    assign acc_unsigned = (state_q == IDLE) ? req_unsigned : unsigned_q;
    assign acc_addr     = (state_q == IDLE) ? req_addr     : addr_q;
    assign acc_wdata    = (state_q == IDLE) ? req_wdata    : wdata_q;
    assign acc_size     = (state_q == IDLE) ? req_size     : size_q;
    assign acc_idx      = acc_addr[IDX_W+1:2];

    assign accept = (state_q == IDLE) && req_valid;

    always_comb begin
        acc_error = 1'b0;
        if (acc_size == 2'b11)                                 acc_error = 1'b1;
        if ((acc_size == SIZE_HALF) && acc_addr[0])            acc_error = 1'b1;
        if ((acc_size == SIZE_WORD) && (acc_addr[1:0] != 2'b00)) acc_error = 1'b1;
        if (acc_addr[31:2] >= 30'(DEPTH_WORDS))                acc_error = 1'b1;
    end

    dmem_lane_unit u_lane (
        .size_i      (acc_size),
        .offset_i    (acc_addr[1:0]),
        .unsigned_i  (acc_unsigned),
        .wdata_i     (acc_wdata),
        .rword_i     (mem_q[acc_idx]),
        .wmask_o     (wmask),
        .wdata_rep_o (wdata_rep),
        .rdata_o     (load_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_STATES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign commit  = enter_resp && acc_write && !acc_error;
    assign rdata_d = (acc_error || acc_write) ? 32'd0 : load_data;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            rdata_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                write_q    <= req_write;
                unsigned_q <= req_unsigned;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                size_q     <= req_size;
            end
            if (enter_resp) begin
                rdata_q <= rdata_d;
                error_q <= acc_error;
            end
        end
    end

    // NOTE: the array is cleared by reset, so it must live in flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
        end else if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) mem_q[acc_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

    assign req_ready         = (state_q == IDLE);
    assign rsp_valid         = (state_q == RESP);
    assign rsp_rdata         = rdata_q;
    assign rsp_error         = error_q;
    assign debug_mem_addr_16 = mem_q[DBG_IDX];

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: three responders (0, 2 and 3 wait states) sharing clock, reset and request data.
module tb_dmem_responder;

    localparam int NUM_DUT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic [NUM_DUT-1:0] req_valid = '0;
    logic [NUM_DUT-1:0] rsp_ready = '0;
    logic [NUM_DUT-1:0] req_ready_w, rsp_valid_w, rsp_error_w;
    logic [31:0] rsp_rdata_w [NUM_DUT];
    logic [31:0] dbg_w       [NUM_DUT];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Index 0: W=0, index 1: W=2, index 2: W=3.
    dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0), .DBG_ADDR(16)) u_w0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready_w[0]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_unsigned(req_unsigned), .rsp_valid(rsp_valid_w[0]),
        .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata_w[0]), .rsp_error(rsp_error_w[0]),
        .debug_mem_addr_16(dbg_w[0])
    );

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(2), .DBG_ADDR(16)) u_w2 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready_w[1]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_unsigned(req_unsigned), .rsp_valid(rsp_valid_w[1]),
        .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata_w[1]), .rsp_error(rsp_error_w[1]),
        .debug_mem_addr_16(dbg_w[1])
    );

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(3), .DBG_ADDR(16)) u_w3 (
        .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready_w[2]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_unsigned(req_unsigned), .rsp_valid(rsp_valid_w[2]),
        .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata_w[2]), .rsp_error(rsp_error_w[2]),
        .debug_mem_addr_16(dbg_w[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Edges counted from the accept edge (inclusive) until rsp_valid is seen high.
    task automatic wait_rsp(input int k, output int lat);
        lat = 1;
        while (!rsp_valid_w[k] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!rsp_valid_w[k]) check("rsp_timeout", 32'(rsp_valid_w[k]), 32'd1);
    endtask

    task automatic set_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [1:0] sz, input logic uns);
        req_write    = wr;
        req_addr     = addr;
        req_wdata    = wd;
        req_size     = sz;
        req_unsigned = uns;
    endtask

    // Called #1 after a rising edge with the addressed responder idle.
    task automatic do_req(input int k, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [1:0] sz, input logic uns,
                          output logic [31:0] rd, output logic er, output int lat);
        set_req(wr, addr, wd, sz, uns);
        req_valid[k] = 1'b1;
        rsp_ready[k] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        wait_rsp(k, lat);
        rd = rsp_rdata_w[k];
        er = rsp_error_w[k];
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_rsp_valid", 32'(rsp_valid_w), 32'd0);
        check("reset_req_ready", 32'(req_ready_w), 32'h7);
        check("reset_rdata_w3", rsp_rdata_w[2], 32'd0);

        // 1: reset in the second wait cycle discards the pending store.
        set_req(1'b1, 32'h10, 32'hCAFE_F00D, 2'b10, 1'b0);
        req_valid[2] = 1'b1;
        @(posedge clk);
        #1 req_valid[2] = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_mid_wait_valid", 32'(rsp_valid_w[2]), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_mid_wait_debug", dbg_w[2], 32'd0);
        check("rst_mid_wait_rsp_valid", 32'(rsp_valid_w[2]), 32'd0);
        check("rst_mid_wait_req_ready", 32'(req_ready_w[2]), 32'd1);
        do_req(2, 1'b0, 32'h10, 32'd0, 2'b10, 1'b0, rd, er, lat);
        check("w3_lw_after_rst", rd, 32'd0);
        check("w3_latency", 32'(lat), 32'd4);

        // 2: zero wait states, sign/zero extension.
        do_req(0, 1'b1, 32'h10, 32'h8000_00F0, 2'b10, 1'b0, rd, er, lat);
        check("w0_sw_rdata", rd, 32'd0);
        check("w0_sw_error", 32'(er), 32'd0);
        check("w0_sw_latency", 32'(lat), 32'd1);
        check("w0_debug", dbg_w[0], 32'h8000_00F0);
        do_req(0, 1'b0, 32'h10, 32'd0, 2'b00, 1'b0, rd, er, lat);
        check("w0_lb", rd, 32'hFFFF_FFF0);
        check("w0_lb_latency", 32'(lat), 32'd1);
        do_req(0, 1'b0, 32'h10, 32'd0, 2'b00, 1'b1, rd, er, lat);
        check("w0_lbu", rd, 32'h0000_00F0);
        do_req(0, 1'b0, 32'h12, 32'd0, 2'b01, 1'b0, rd, er, lat);
        check("w0_lh_hi", rd, 32'hFFFF_8000);
        do_req(0, 1'b0, 32'h12, 32'd0, 2'b01, 1'b1, rd, er, lat);
        check("w0_lhu_hi", rd, 32'h0000_8000);

        // 3: two wait states, lane placement.
        do_req(1, 1'b1, 32'h22, 32'h0000_BEEF, 2'b01, 1'b0, rd, er, lat);
        do_req(1, 1'b0, 32'h20, 32'd0, 2'b10, 1'b0, rd, er, lat);
        check("w2_lw_after_sh", rd, 32'hBEEF_0000);
        check("w2_latency", 32'(lat), 32'd3);
        do_req(1, 1'b1, 32'h21, 32'h0000_005A, 2'b00, 1'b0, rd, er, lat);
        do_req(1, 1'b0, 32'h20, 32'd0, 2'b10, 1'b1, rd, er, lat);
        check("w2_lw_after_sb", rd, 32'hBEEF_5A00);
        do_req(1, 1'b0, 32'h23, 32'd0, 2'b00, 1'b0, rd, er, lat);
        check("w2_lb_lane3", rd, 32'hFFFF_FFBE);
        do_req(1, 1'b0, 32'h21, 32'd0, 2'b00, 1'b1, rd, er, lat);
        check("w2_lbu_lane1", rd, 32'h0000_005A);

        // 4: error cases leave memory untouched.
        do_req(0, 1'b0, 32'h21, 32'd0, 2'b10, 1'b0, rd, er, lat);
        check("err_lw_misalign", {rd[30:0], er}, 32'd1);
        do_req(0, 1'b1, 32'h13, 32'h0000_1234, 2'b01, 1'b0, rd, er, lat);
        check("err_sh_misalign", {rd[30:0], er}, 32'd1);
        do_req(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 2'b11, 1'b0, rd, er, lat);
        check("err_size11", {rd[30:0], er}, 32'd1);
        do_req(0, 1'b0, 32'h100, 32'd0, 2'b10, 1'b0, rd, er, lat);
        check("err_lw_range", {rd[30:0], er}, 32'd1);
        check("err_lw_range_rdata", rd, 32'd0);
        do_req(0, 1'b1, 32'h110, 32'hDEAD_BEEF, 2'b10, 1'b0, rd, er, lat);
        check("err_sw_range", {rd[30:0], er}, 32'd1);
        check("err_mem_unchanged", dbg_w[0], 32'h8000_00F0);
        do_req(0, 1'b0, 32'hFC, 32'd0, 2'b10, 1'b0, rd, er, lat);
        check("last_word_ok", {rd[30:0], er}, 32'd0);
        do_req(0, 1'b1, 32'h13, 32'h0000_007F, 2'b00, 1'b0, rd, er, lat);
        check("sb_lane3_error", 32'(er), 32'd0);
        check("sb_lane3_debug", dbg_w[0], 32'h7F00_00F0);

        // 5: response backpressure; a waiting request is taken only after the handshake.
        set_req(1'b0, 32'h20, 32'd0, 2'b10, 1'b0);
        req_valid[1] = 1'b1;
        rsp_ready[1] = 1'b0;
        @(posedge clk);
        #1;
        set_req(1'b1, 32'h20, 32'h1111_1111, 2'b10, 1'b0);
        wait_rsp(1, lat);
        for (int c = 0; c < 5; c++) begin
            check("bp_rsp_valid", 32'(rsp_valid_w[1]), 32'd1);
            check("bp_rdata", rsp_rdata_w[1], 32'hBEEF_5A00);
            check("bp_req_ready", 32'(req_ready_w[1]), 32'd0);
            @(posedge clk);
            #1;
        end
        rsp_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        check("bp_after_hs_valid", 32'(rsp_valid_w[1]), 32'd0);
        check("bp_after_hs_ready", 32'(req_ready_w[1]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        check("bp_next_accepted", 32'(req_ready_w[1]), 32'd0);
        wait_rsp(1, lat);
        check("bp_store_rdata", rsp_rdata_w[1], 32'd0);
        @(posedge clk);
        #1;
        do_req(1, 1'b0, 32'h20, 32'd0, 2'b10, 1'b0, rd, er, lat);
        check("bp_store_landed", rd, 32'h1111_1111);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
